// File: rtl/nms_layer_ctrl.sv
// nms_layer_ctrl: layer/iteration sequencing FSM for the NMS QC-LDPC decoder core
module nms_layer_ctrl #(
  parameter int NUM_LAYERS = 4,
  parameter int ITER_W = 5,
  parameter int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [ITER_W-1:0]  max_iter_i,
  input  logic               early_term_en_i,
  input  logic               abort_i,
  input  logic               load_done_i,
  input  logic               sort_done_i,
  input  logic               store_done_i,
  input  logic               judge_done_i,
  input  logic               syndrome_ok_i,
  output logic               load_en_o,
  output logic               sort_en_o,
  output logic               cnu_load_o,
  output logic [LAYER_W-1:0] layer_idx_o,
  output logic               judge_o,
  output logic               clr_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               converged_o,
  output logic [ITER_W-1:0]  iter_cnt_o
);
  typedef enum logic [2:0] {IDLE, LOAD, SORT, CNU, STORE, JUDGE, DONE} state_t;
  localparam logic [LAYER_W-1:0] LAST = LAYER_W'(NUM_LAYERS - 1);
  state_t state, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [ITER_W-1:0] iter_q, iter_d, max_q, max_d;
  logic et_q, et_d, conv_q, conv_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      layer_q <= '0;
      iter_q <= '0;
      max_q <= '0;
      et_q <= 1'b0;
      conv_q <= 1'b0;
    end else begin
      state <= state_d;
      layer_q <= layer_d;
      iter_q <= iter_d;
      max_q <= max_d;
      et_q <= et_d;
      conv_q <= conv_d;
    end
  end
  // abort overrides every handshake and freezes the counters where they stand
  always_comb begin
    state_d = state;
    layer_d = layer_q;
    iter_d = iter_q;
    max_d = max_q;
    et_d = et_q;
    conv_d = conv_q;
    if (abort_i && state != IDLE && state != DONE) begin
      state_d = DONE;
      conv_d = 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state_d = LOAD;
          max_d = (max_iter_i == '0) ? ITER_W'(1) : max_iter_i;
          et_d = early_term_en_i;
          layer_d = '0;
          iter_d = '0;
          conv_d = 1'b0;
        end
        LOAD: state_d = load_done_i ? SORT : LOAD;
        SORT: state_d = sort_done_i ? CNU : SORT;
        CNU: state_d = STORE;
        STORE: if (store_done_i) begin
          state_d = (layer_q == LAST) ? JUDGE : SORT;
          layer_d = (layer_q == LAST) ? '0 : layer_q + 1'b1;
          iter_d = (layer_q == LAST) ? iter_q + ITER_W'(iter_q != '1) : iter_q;
        end
        JUDGE: if (judge_done_i) begin
          state_d = ((et_q && syndrome_ok_i) || iter_q >= max_q) ? DONE : SORT;
          conv_d = (state_d == DONE) ? syndrome_ok_i : conv_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign load_en_o = state == LOAD;
  assign sort_en_o = state == SORT;
  assign cnu_load_o = state == CNU;
  assign judge_o = state == JUDGE;
  assign done_o = state == DONE;
  assign clr_o = state == DONE;
  assign busy_o = state != IDLE;
  assign layer_idx_o = layer_q;
  assign iter_cnt_o = iter_q;
  assign converged_o = conv_q;
endmodule

// File: tb/tb_nms_layer_ctrl.sv
// tb_nms_layer_ctrl: vector table, hand sequences and random decodes vs a transaction-level model
module tb_nms_layer_ctrl;
  localparam int NL = 4;
  localparam int IW = 5;
  localparam int LW = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic start_i = 0, early_term_en_i = 0, abort_i = 0;
  logic load_done_i = 0, sort_done_i = 0, store_done_i = 0, judge_done_i = 0, syndrome_ok_i = 0;
  logic [IW-1:0] max_iter_i = '0;
  logic load_en_o, sort_en_o, cnu_load_o, judge_o, clr_o, busy_o, done_o, converged_o;
  logic [LW-1:0] layer_idx_o;
  logic [IW-1:0] iter_cnt_o;
  nms_layer_ctrl #(.NUM_LAYERS(NL), .ITER_W(IW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .max_iter_i(max_iter_i),
    .early_term_en_i(early_term_en_i), .abort_i(abort_i), .load_done_i(load_done_i),
    .sort_done_i(sort_done_i), .store_done_i(store_done_i), .judge_done_i(judge_done_i),
    .syndrome_ok_i(syndrome_ok_i), .load_en_o(load_en_o), .sort_en_o(sort_en_o),
    .cnu_load_o(cnu_load_o), .layer_idx_o(layer_idx_o), .judge_o(judge_o), .clr_o(clr_o),
    .busy_o(busy_o), .done_o(done_o), .converged_o(converged_o), .iter_cnt_o(iter_cnt_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    int mi; bit et; logic [15:0] okm; bit hold; bit stray; int dly; int ab;
    int e_it; bit e_conv; int e_cnu; int e_lay;
  } vec_t;
  vec_t vecs[8];
  int passed = 0, total = 0;
  int r_cnu, r_it, r_conv, r_dn, r_jn, r_lay, r_seq_err, r_clr_err, r_cycles;
  bit r_timeout, r_busy_fall;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  function automatic void model(input int mi, input bit et, input logic [15:0] okm,
                                output int it, output bit conv);
    int lim = (mi == 0) ? 1 : mi;
    it = lim;
    conv = okm[lim-1];
    for (int k = 1; k <= lim; k++)
      if ((et && okm[k-1]) || k == lim) begin
        it = k;
        conv = okm[k-1];
        break;
      end
  endfunction
  // a responder: strobes each handshake after it has been enabled for dly+1 cycles
  task automatic run(input vec_t v);
    int ph, pph, w;
    bit seen;
    r_cnu = 0; r_it = -1; r_conv = 0; r_dn = 0; r_jn = 0; r_lay = -1;
    r_seq_err = 0; r_clr_err = 0; r_cycles = 0; r_timeout = 1; r_busy_fall = 0;
    @(negedge clk);
    start_i = 1; max_iter_i = IW'(v.mi); early_term_en_i = v.et;
    @(negedge clk);
    check("load_after_start", int'(load_en_o), 1);
    if (!v.hold) start_i = 0;
    pph = -1; w = 0; seen = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ph = load_en_o ? 1 : sort_en_o ? 2 : cnu_load_o ? 3 : judge_o ? 5 : done_o ? 6 : busy_o ? 4 : 0;
      w = (ph == pph) ? w + 1 : 0;
      pph = ph;
      if (seen) begin
        r_busy_fall = !busy_o;
        r_timeout = 0;
        break;
      end
      if (busy_o) r_cycles++;
      abort_i = ph == 4 && v.ab >= 0 && r_cnu == v.ab + 1;
      load_done_i = ph == 1 && w >= v.dly;
      sort_done_i = (ph == 2 && w >= v.dly) || (ph == 1 && v.stray);
      store_done_i = ph == 4 && (w >= v.dly || abort_i);
      judge_done_i = ph == 5 && w >= v.dly;
      syndrome_ok_i = judge_done_i && v.okm[r_jn];
      if (judge_done_i) r_jn++;
      if (ph == 3) begin
        if (int'(layer_idx_o) != r_cnu % NL) r_seq_err++;
        r_cnu++;
      end
      if (ph == 6) begin
        r_dn++; seen = 1;
        r_it = int'(iter_cnt_o); r_conv = int'(converged_o); r_lay = int'(layer_idx_o);
        if (!clr_o) r_clr_err++;
      end
      if (clr_o && !done_o) r_clr_err++;
      @(negedge clk);
    end
    {start_i, abort_i, load_done_i, sort_done_i, store_done_i, judge_done_i, syndrome_ok_i} = '0;
    if (r_timeout) $display("FAIL timeout: got %0d expected %0d", 1, 0);
    check("no_timeout", int'(r_timeout), 0);
  endtask
  task automatic score(input vec_t v, input string tag);
    int d = v.dly + 1;
    check({tag, "_iter"}, r_it, v.e_it);
    check({tag, "_conv"}, r_conv, int'(v.e_conv));
    check({tag, "_cnu"}, r_cnu, v.e_cnu);
    check({tag, "_judges"}, r_jn, (v.ab >= 0) ? 0 : v.e_it);
    check({tag, "_done_cnt"}, r_dn, 1);
    check({tag, "_layer_at_done"}, r_lay, v.e_lay);
    check({tag, "_layer_seq_err"}, r_seq_err, 0);
    check({tag, "_clr_err"}, r_clr_err, 0);
    check({tag, "_busy_fall"}, int'(r_busy_fall), 1);
    if (v.ab < 0) check({tag, "_cycles"}, r_cycles, d + v.e_cnu * (2 * d + 1) + v.e_it * d + 1);
    @(negedge clk);
    check({tag, "_idle_stays"}, int'(busy_o), 0);
    check({tag, "_iter_held"}, int'(iter_cnt_o), v.e_it);
    check({tag, "_conv_held"}, int'(converged_o), int'(v.e_conv));
  endtask
  initial begin
    vec_t rv;
    int it;
    bit cv;
    vecs[0] = '{3, 0, 16'h0000, 0, 0, 0, -1, 3, 0, 12, 0};
    vecs[1] = '{10, 1, 16'h0002, 0, 0, 0, -1, 2, 1, 8, 0};
    vecs[2] = '{0, 0, 16'h0000, 0, 0, 1, -1, 1, 0, 4, 0};
    vecs[3] = '{2, 0, 16'h0003, 0, 0, 0, -1, 2, 1, 8, 0};
    vecs[4] = '{3, 0, 16'h0001, 0, 0, 2, -1, 3, 0, 12, 0};
    vecs[5] = '{1, 1, 16'h0000, 1, 1, 2, -1, 1, 0, 4, 0};
    vecs[6] = '{3, 0, 16'h0000, 0, 0, 1, 1, 0, 0, 2, 1};
    vecs[7] = '{1, 1, 16'h0001, 1, 0, 0, -1, 1, 1, 4, 0};
    #12;
    check("reset_outputs", int'({load_en_o, sort_en_o, cnu_load_o, layer_idx_o, judge_o, clr_o,
                                 busy_o, done_o, converged_o, iter_cnt_o}), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("idle_after_reset", int'(busy_o), 0);
    for (int i = 0; i < 8; i++) begin
      run(vecs[i]);
      score(vecs[i], $sformatf("vec%0d", i));
    end
    // reset in the middle of the SORT of layer 2
    @(negedge clk);
    start_i = 1; max_iter_i = 5'd3; early_term_en_i = 0;
    @(negedge clk);
    start_i = 0;
    for (int cyc = 0; cyc < 100 && !(sort_en_o && layer_idx_o == 2'd2); cyc++) begin
      load_done_i = load_en_o;
      sort_done_i = sort_en_o;
      store_done_i = busy_o && !load_en_o && !sort_en_o && !cnu_load_o && !judge_o && !done_o;
      @(negedge clk);
    end
    {load_done_i, sort_done_i, store_done_i} = '0;
    check("reached_layer2_sort", int'(sort_en_o && layer_idx_o == 2'd2), 1);
    rst = 1;
    #1;
    check("midreset_outputs", int'({load_en_o, sort_en_o, cnu_load_o, layer_idx_o, judge_o, clr_o,
                                    busy_o, done_o, converged_o, iter_cnt_o}), 0);
    @(negedge clk);
    rst = 0;
    run(vecs[0]);
    score(vecs[0], "after_midreset");
    for (int i = 0; i < 12; i++) begin
      rv.mi = $urandom_range(0, 6);
      rv.et = 1'($urandom_range(0, 1));
      rv.okm = 16'($urandom & $urandom);
      rv.hold = 1'($urandom_range(0, 1));
      rv.stray = 1'($urandom_range(0, 1));
      rv.dly = $urandom_range(0, 2);
      rv.ab = -1;
      model(rv.mi, rv.et, rv.okm, it, cv);
      rv.e_it = it; rv.e_conv = cv; rv.e_cnu = it * NL; rv.e_lay = 0;
      run(rv);
      score(rv, $sformatf("rnd%0d", i));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
